// File: rtl/branch_resolution_unit_pkg.sv
// Shared opcode / funct3 constants for control-flow resolution, plus the
// predictor PHT index width default.
//   PHT_IDX_WIDTH_DEF : gshare PHT index width shared with the predictor
//   OPC_BRANCH/JAL/JALR : RV32I major opcodes for control instructions
//   branch_f3_e        : funct3 encodings of the conditional branches
//   is_ctrl_op()       : true for opcodes that update the predictor
package branch_resolution_unit_pkg;

  localparam int PHT_IDX_WIDTH_DEF = 5;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
  endfunction

endpackage

// File: rtl/branch_resolution_unit_comparator.sv
// Combinational branch condition evaluator.
//   funct3 : branch kind (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   rs1/rs2: forwarded operands
//   taken  : condition holds; reserved funct3 values report not taken
module branch_comparator
  import branch_resolution_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Branch resolution unit: carries IF prediction metadata through IF/ID and
// ID/EX, resolves the EX instruction, raises flush/redirect on mispredict,
// emits the predictor update bundle and keeps saturating perf counters.
//   clk, reset            : clock, synchronous active-high reset
//   if_*                  : IF-stage valid, pc, predicted next pc, PHT index
//   stall                 : hold IF/ID, bubble into ID/EX
//   ex_*                  : EX-stage decode fields and forwarded operands
//   upd_*                 : predictor update bundle
//   flush, redirect_pc    : mispredict kill + correct next pc
//   cnt_ctrl, cnt_mispred : resolved control / mispredict counts
// upd_valid is a one-cycle pulse with no ready: each control instruction in
// EX is presented exactly once and the predictor must accept it that cycle.
module branch_resolution_unit
  import branch_resolution_unit_pkg::*;
#(
  parameter int PHT_IDX_WIDTH = PHT_IDX_WIDTH_DEF,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_pred_next_pc,
  input  logic [PHT_IDX_WIDTH-1:0] if_pht_idx,
  input  logic                     stall,
  input  logic [6:0]               ex_opcode,
  input  logic [2:0]               ex_funct3,
  input  logic [31:0]              ex_rs1,
  input  logic [31:0]              ex_rs2,
  input  logic [31:0]              ex_imm,
  output logic                     upd_valid,
  output logic [6:0]               upd_opcode,
  output logic [31:0]              upd_pc,
  output logic [PHT_IDX_WIDTH-1:0] upd_pht_idx,
  output logic [31:0]              upd_pred_target,
  output logic [31:0]              upd_actual_target,
  output logic                     upd_taken,
  output logic                     flush,
  output logic [31:0]              redirect_pc,
  output logic [CNT_WIDTH-1:0]     cnt_ctrl,
  output logic [CNT_WIDTH-1:0]     cnt_mispred
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                     ifid_valid, idex_valid;
  logic [31:0]              ifid_pc, idex_pc;
  logic [31:0]              ifid_pred, idex_pred;
  logic [PHT_IDX_WIDTH-1:0] ifid_idx, idex_idx;

  // Pipeline metadata. Flush wins over stall; ID/EX data simply follows
  // IF/ID because its valid bit alone decides whether EX acts on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_pred  <= '0;
      ifid_idx   <= '0;
      idex_valid <= 1'b0;
      idex_pc    <= '0;
      idex_pred  <= '0;
      idex_idx   <= '0;
    end else begin
      if (flush) begin
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        ifid_valid <= if_valid;
      end
      if (flush || !stall) begin
        ifid_pc   <= if_pc;
        ifid_pred <= if_pred_next_pc;
        ifid_idx  <= if_pht_idx;
      end
      idex_valid <= ifid_valid && !stall && !flush;
      idex_pc    <= ifid_pc;
      idex_pred  <= ifid_pred;
      idex_idx   <= ifid_idx;
    end
  end

  logic        is_branch, is_jal, is_jalr, cmp_taken, taken;
  logic [31:0] pc_seq, jalr_sum, target, actual_next;

  branch_comparator u_cmp (
    .funct3 (ex_funct3),
    .rs1    (ex_rs1),
    .rs2    (ex_rs2),
    .taken  (cmp_taken)
  );

  always_comb begin
    is_branch   = (ex_opcode == OPC_BRANCH);
    is_jal      = (ex_opcode == OPC_JAL);
    is_jalr     = (ex_opcode == OPC_JALR);
    pc_seq      = idex_pc + 32'd4;
    jalr_sum    = ex_rs1 + ex_imm;
    target      = is_jalr ? {jalr_sum[31:1], 1'b0} : (idex_pc + ex_imm);
    // Non-control opcodes fall through as not taken.
    taken       = is_branch ? cmp_taken : (is_jal || is_jalr);
    actual_next = taken ? target : pc_seq;
    flush       = idex_valid && (actual_next != idex_pred);
    if (flush) begin
      redirect_pc = actual_next;
    end else if (idex_valid) begin
      redirect_pc = pc_seq;
    end else begin
      redirect_pc = '0;
    end
    upd_valid         = idex_valid && is_ctrl_op(ex_opcode);
    upd_opcode        = ex_opcode;
    upd_pc            = idex_pc;
    upd_pht_idx       = idex_idx;
    upd_pred_target   = idex_pred;
    upd_actual_target = target;
    upd_taken         = taken;
  end

  // Counters register this cycle's resolution, so a reset in the same
  // cycle drops the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_ctrl    <= '0;
      cnt_mispred <= '0;
    end else begin
      if (upd_valid && (cnt_ctrl != CNT_MAX)) begin
        cnt_ctrl <= cnt_ctrl + CNT_ONE;
      end
      if (upd_valid && flush && (cnt_mispred != CNT_MAX)) begin
        cnt_mispred <= cnt_mispred + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench for branch_resolution_unit: a driver pushes the expected
// EX-cycle response of every instruction reaching EX, a negedge monitor pops
// and compares, and also tracks the saturating counters.
module tb_branch_resolution_unit;

  localparam int PW   = 5;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6f;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_ALU  = 7'h33;
  localparam logic [6:0] OP_LD   = 7'h03;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_valid;
  logic [31:0]   if_pc, if_pred_next_pc;
  logic [PW-1:0] if_pht_idx;
  logic          stall;
  logic [6:0]    ex_opcode;
  logic [2:0]    ex_funct3;
  logic [31:0]   ex_rs1, ex_rs2, ex_imm;
  logic          upd_valid, upd_taken, flush;
  logic [6:0]    upd_opcode;
  logic [31:0]   upd_pc, upd_pred_target, upd_actual_target, redirect_pc;
  logic [PW-1:0] upd_pht_idx;
  logic [CW-1:0] cnt_ctrl, cnt_mispred;

  branch_resolution_unit #(.PHT_IDX_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_pc(if_pc), .if_pred_next_pc(if_pred_next_pc),
    .if_pht_idx(if_pht_idx), .stall(stall),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .upd_valid(upd_valid), .upd_opcode(upd_opcode), .upd_pc(upd_pc),
    .upd_pht_idx(upd_pht_idx), .upd_pred_target(upd_pred_target),
    .upd_actual_target(upd_actual_target), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc),
    .cnt_ctrl(cnt_ctrl), .cnt_mispred(cnt_mispred)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- types and model ----------------
  typedef struct {
    bit            valid;
    logic [31:0]   pc, pred;
    logic [PW-1:0] idx;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [31:0]   rs1, rs2, imm;
  } instr_t;

  typedef struct {
    int            cyc;
    bit            flush, upd_valid, taken;
    logic [31:0]   redirect, next, target, pc, pred;
    logic [PW-1:0] idx;
    logic [6:0]    opcode;
  } exp_t;

  exp_t   exp_q[$];
  instr_t ifid, idex, bubble;
  int     n_cmp = 0, n_bad = 0;
  int     mdl_ctrl = 0, mdl_mis = 0;
  bit     mon_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit br_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    int sa = a;
    int sb = b;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(instr_t i);
    exp_t e;
    logic [31:0] seq = i.pc + 32'd4;
    e.cyc = 0;
    e.taken = 1'b0;
    e.target = i.pc + i.imm;
    e.upd_valid = 1'b1;
    if (i.opcode == OP_BR) e.taken = br_taken(i.funct3, i.rs1, i.rs2);
    else if (i.opcode == OP_JAL) e.taken = 1'b1;
    else if (i.opcode == OP_JALR) begin
      e.taken = 1'b1;
      e.target = (i.rs1 + i.imm) & 32'hFFFF_FFFE;
    end else e.upd_valid = 1'b0;
    e.next     = e.taken ? e.target : seq;
    e.flush    = (e.next != i.pred);
    e.redirect = e.flush ? e.next : seq;
    e.pc       = i.pc;
    e.pred     = i.pred;
    e.idx      = i.idx;
    e.opcode   = i.opcode;
    return e;
  endfunction

  function automatic instr_t mk(bit v, logic [6:0] op, logic [2:0] f3, logic [31:0] pc,
                                logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                logic [31:0] pred);
    instr_t i;
    i.valid = v; i.opcode = op; i.funct3 = f3; i.pc = pc;
    i.rs1 = a; i.rs2 = b; i.imm = imm; i.pred = pred;
    i.idx = PW'($urandom_range(0, (1 << PW) - 1));
    return i;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'($urandom_range(0, 3));
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    exp_t   e;
    logic [6:0] op;
    int imm_s = $urandom_range(0, 8191) - 4096;
    case ($urandom_range(0, 5))
      0, 1:    op = OP_BR;
      2:       op = OP_JAL;
      3:       op = OP_JALR;
      4:       op = OP_ALU;
      default: op = OP_LD;
    endcase
    i = mk($urandom_range(0, 9) < 8, op, 3'($urandom_range(0, 7)),
           $urandom & 32'hFFFF_FFFC, rand_opnd(), rand_opnd(), 32'(imm_s), 32'h0);
    case ($urandom_range(0, 2))
      0: i.pred = i.pc + 32'd4;
      1: begin e = model(i); i.pred = e.next; end
      default: i.pred = $urandom & 32'hFFFF_FFFC;
    endcase
    return i;
  endfunction

  // ---------------- driver ----------------
  // One cycle: drive IF with nxt, EX fields from the modelled ID/EX slot,
  // queue the expected EX response, then advance the occupancy model.
  task automatic step(input instr_t nxt, input bit stl, input bit rst);
    exp_t e;
    bit   fl = 1'b0;
    if_valid = nxt.valid; if_pc = nxt.pc; if_pred_next_pc = nxt.pred;
    if_pht_idx = nxt.idx; stall = stl; reset = rst;
    ex_opcode = idex.opcode; ex_funct3 = idex.funct3;
    ex_rs1 = idex.rs1; ex_rs2 = idex.rs2; ex_imm = idex.imm;
    if (idex.valid) begin
      e = model(idex);
      e.cyc = cyc;
      exp_q.push_back(e);
      fl = e.flush;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      ifid.valid = 1'b0; idex.valid = 1'b0;
      exp_q.delete();
      mdl_ctrl = 0; mdl_mis = 0;
    end else if (fl) begin
      ifid.valid = 1'b0; idex.valid = 1'b0;
    end else if (stl) begin
      idex.valid = 1'b0;
    end else begin
      idex = ifid;
      ifid = nxt;
    end
  endtask

  task automatic run_one(input instr_t i);
    step(i, 0, 0);
    step(bubble, 0, 0);
    step(bubble, 0, 0);
    step(bubble, 0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      chk("cnt_ctrl", cnt_ctrl, mdl_ctrl);
      chk("cnt_mispred", cnt_mispred, mdl_mis);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("flush", flush, e.flush);
        chk("redirect_pc", redirect_pc, e.redirect);
        chk("upd_valid", upd_valid, e.upd_valid);
        if (e.upd_valid) begin
          chk("upd_taken", upd_taken, e.taken);
          chk("upd_actual_target", upd_actual_target, e.target);
          chk("upd_pc", upd_pc, e.pc);
          chk("upd_pred_target", upd_pred_target, e.pred);
          chk("upd_pht_idx", upd_pht_idx, e.idx);
          chk("upd_opcode", upd_opcode, e.opcode);
          if (mdl_ctrl < CMAX) mdl_ctrl++;
          if (e.flush && mdl_mis < CMAX) mdl_mis++;
        end
      end else begin
        chk("idle_flush", flush, 0);
        chk("idle_upd_valid", upd_valid, 0);
        chk("idle_redirect_pc", redirect_pc, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    instr_t a, b;
    bubble = mk(0, OP_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4);
    ifid = bubble;
    idex = bubble;
    reset = 1'b1; stall = 1'b0; if_valid = 1'b0; if_pc = '0;
    if_pred_next_pc = '0; if_pht_idx = '0;
    ex_opcode = '0; ex_funct3 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(bubble, 0, 0);
    step(bubble, 0, 0);

    // BEQ taken, predicted fall-through
    run_one(mk(1, OP_BR, 3'd0, 32'h100, 32'd5, 32'd5, 32'h40, 32'h104));
    // BNE not taken, correctly predicted
    run_one(mk(1, OP_BR, 3'd1, 32'h200, 32'd7, 32'd7, 32'h40, 32'h204));
    // JALR bit0 clearing: correct and wrong prediction
    run_one(mk(1, OP_JALR, 3'd0, 32'h300, 32'h1001, 32'd0, 32'd4, 32'h1004));
    run_one(mk(1, OP_JALR, 3'd0, 32'h300, 32'h1001, 32'd0, 32'd4, 32'h2000));
    // signed vs unsigned less-than
    run_one(mk(1, OP_BR, 3'd4, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h404));
    run_one(mk(1, OP_BR, 3'd6, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h504));
    // branch held in ID by a two-cycle stall
    step(mk(1, OP_BR, 3'd5, 32'h600, 32'd9, 32'd3, 32'h80, 32'h604), 0, 0);
    step(mk(1, OP_ALU, 3'd0, 32'h604, 0, 0, 0, 32'h608), 1, 0);
    step(mk(1, OP_ALU, 3'd0, 32'h604, 0, 0, 0, 32'h608), 1, 0);
    step(bubble, 0, 0);
    step(bubble, 0, 0);
    step(bubble, 0, 0);
    // mispredict in EX while stalled: younger instructions are killed
    a = mk(1, OP_JAL, 3'd0, 32'h700, 0, 0, 32'h100, 32'h704);
    b = mk(1, OP_BR, 3'd0, 32'h704, 32'd1, 32'd1, 32'h10, 32'h708);
    step(a, 0, 0);
    step(b, 0, 0);
    step(mk(1, OP_BR, 3'd0, 32'h708, 1, 1, 32'h10, 32'h70c), 1, 0);
    step(bubble, 0, 0);
    step(bubble, 0, 0);
    step(bubble, 0, 0);
    // reset lands in the mispredict cycle: its increment is dropped
    step(mk(1, OP_BR, 3'd0, 32'h800, 32'd2, 32'd2, 32'h40, 32'h804), 0, 0);
    step(bubble, 0, 0);
    step(bubble, 1, 1);
    step(bubble, 0, 0);
    step(bubble, 0, 0);

    // randomized traffic, long enough to drive both counters into saturation
    for (int n = 0; n < 1500; n++) begin
      step(rand_instr(), $urandom_range(0, 9) < 2, 0);
    end
    repeat (4) step(bubble, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("cnt_ctrl_saturated", cnt_ctrl, CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
